// File: rtl/pwm_bank_pkg.sv
// Shared constants and types for the PWM bank: register map, ctrl bit positions, bus widths.
package pwm_bank_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_PRESC  = 4'd9;
  localparam logic [ADDR_W-1:0] ADDR_EN     = 4'd10;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd11;

  localparam int unsigned CTRL_RUN = 0;
  localparam int unsigned CTRL_INV = 1;

  typedef struct packed {
    logic invert;
    logic run;
  } ctrl_t;

endpackage

// File: rtl/pwm_bank_if.sv
// Register access bus of the PWM bank: write strobe/address/data and registered readback.
interface pwm_bank_if;
  import pwm_bank_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, output addr, output wr_data, input  rd_data);
  modport slave  (input  wr_en, input  addr, input  wr_data, output rd_data);

endinterface

// File: rtl/pwm_cmp.sv
// One PWM channel: duty shadow/active pair, compare against the shared counter, output flop.
module pwm_cmp #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load,
  input  logic [CNT_W-1:0] count,
  input  logic             gate,
  input  logic             invert,
  output logic [CNT_W-1:0] duty_shadow,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_act;

  // Active copy samples the pre-write shadow, so a write coincident with load waits one period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
      duty_act    <= '0;
      pwm         <= 1'b0;
    end else begin
      if (wr_en) duty_shadow <= wr_data;
      if (load)  duty_act    <= duty_shadow;
      pwm <= (gate & (duty_act > count)) ^ invert;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: register decode, prescaler, shared period counter, per-channel compare.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_bank_if.slave         bus,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cycle_start
);

  logic [CNT_W-1:0]  period_sh;
  logic [CNT_W-1:0]  period_act;
  logic [PRE_W-1:0]  presc_sh;
  logic [PRE_W-1:0]  presc_act;
  logic [NUM_CH-1:0] en;
  ctrl_t             ctrl;

  logic [PRE_W-1:0]  presc_cnt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  duty_sh [NUM_CH];

  logic              tick_c;
  logic              wrap_c;
  logic              load_c;
  logic [NUM_CH-1:0] duty_we_c;
  logic              period_we_c;
  logic              presc_we_c;
  logic              en_we_c;
  logic              ctrl_we_c;
  logic [DATA_W-1:0] rd_c;

  // Write decode; unmapped addresses produce no strobe.
  always_comb begin
    duty_we_c   = '0;
    period_we_c = 1'b0;
    presc_we_c  = 1'b0;
    en_we_c     = 1'b0;
    ctrl_we_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      duty_we_c[i] = bus.wr_en && (bus.addr == ADDR_W'(i));
    end
    if (bus.wr_en) begin
      case (bus.addr)
        ADDR_PERIOD: period_we_c = 1'b1;
        ADDR_PRESC:  presc_we_c  = 1'b1;
        ADDR_EN:     en_we_c     = 1'b1;
        ADDR_CTRL:   ctrl_we_c   = 1'b1;
        default:     ;
      endcase
    end
  end

  // Readback mux over the shadow copies, zero-extended.
  always_comb begin
    rd_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.addr == ADDR_W'(i)) rd_c = DATA_W'(duty_sh[i]);
    end
    case (bus.addr)
      ADDR_PERIOD: rd_c = DATA_W'(period_sh);
      ADDR_PRESC:  rd_c = DATA_W'(presc_sh);
      ADDR_EN:     rd_c = DATA_W'(en);
      ADDR_CTRL:   rd_c = DATA_W'({ctrl.invert, ctrl.run});
      default:     ;
    endcase
  end

  // While stopped the active set tracks the shadows, so a restart begins with current values.
  assign tick_c = ctrl.run && (presc_cnt == presc_act);
  assign wrap_c = tick_c && (count >= period_act);
  assign load_c = !ctrl.run || wrap_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh   <= '0;
      period_act  <= '0;
      presc_sh    <= '0;
      presc_act   <= '0;
      en          <= '0;
      ctrl        <= '0;
      rd_data_clr();
    end else begin
      if (period_we_c) period_sh <= CNT_W'(bus.wr_data);
      if (presc_we_c)  presc_sh  <= PRE_W'(bus.wr_data);
      if (en_we_c)     en        <= NUM_CH'(bus.wr_data);
      if (ctrl_we_c) begin
        ctrl.run    <= bus.wr_data[CTRL_RUN];
        ctrl.invert <= bus.wr_data[CTRL_INV];
      end
      if (load_c) begin
        period_act <= period_sh;
        presc_act  <= presc_sh;
      end
    end
  end

  // No-op reset hook; the readback flop is cleared in its own block below.
  function automatic void rd_data_clr();
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
    end else begin
      bus.rd_data <= rd_c;
    end
  end

  // Prescaler and period counter, both parked at zero while stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt   <= '0;
      count       <= '0;
      cycle_start <= 1'b0;
    end else begin
      cycle_start <= wrap_c;
      if (!ctrl.run) begin
        presc_cnt <= '0;
        count     <= '0;
      end else if (tick_c) begin
        presc_cnt <= '0;
        count     <= wrap_c ? '0 : count + CNT_W'(1);
      end else begin
        presc_cnt <= presc_cnt + PRE_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_cmp #(
      .CNT_W(CNT_W)
    ) u_cmp (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (duty_we_c[g]),
      .wr_data     (CNT_W'(bus.wr_data)),
      .load        (load_c),
      .count       (count),
      .gate        (ctrl.run & en[g]),
      .invert      (ctrl.invert),
      .duty_shadow (duty_sh[g]),
      .pwm         (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: period/high-time windows bounded by cycle_start, plus readback checks.
module tb_pwm_bank;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PRE_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] pwm_out;
  logic              cycle_start;

  pwm_bank_if bus();

  pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .pwm_out     (pwm_out),
    .cycle_start (cycle_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string            name;
    int               len;
    logic [7:0][7:0]  hi;
    time              t_push;
  } per_t;

  typedef struct {
    string       name;
    logic [15:0] val;
  } rd_t;

  per_t per_q[$];
  rd_t  rd_q[$];

  // Period monitor: windows aligned so pwm_out samples cover counts 0..period exactly.
  logic            cs_d = 1'b0;
  bit              win_open = 1'b0;
  time             win_start = 0;
  int              win_len = 0;
  logic [7:0][7:0] win_hi = '0;

  always @(posedge clk) cs_d <= cycle_start;

  task automatic close_window();
    per_t e;
    if (per_q.size() > 0 && per_q[0].t_push < win_start) begin
      e = per_q.pop_front();
      check({e.name, " period"}, 64'(win_len), 64'(e.len));
      check({e.name, " high"}, win_hi, e.hi);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      win_open = 1'b0;
    end else begin
      if (cs_d) begin
        if (win_open) close_window();
        win_open  = 1'b1;
        win_start = $time;
        win_len   = 0;
        win_hi    = '0;
      end
      if (win_open) begin
        win_len++;
        for (int i = 0; i < 8; i++) win_hi[i] = win_hi[i] + 8'(pwm_out[i]);
      end
    end
  end

  // Readback monitor: rd_data is compared the cycle after the address was presented.
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_q: readback with no expected entry, got 0x%0h", bus.rd_data);
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        check(e.name, 64'(bus.rd_data), 64'(e.val));
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [15:0] exp);
    rd_t e;
    @(posedge clk); #1;
    bus.addr = a;
    rd_req   = 1'b1;
    e.name   = name;
    e.val    = exp;
    rd_q.push_back(e);
    @(posedge clk); #1;
    rd_req   = 1'b0;
  endtask

  task automatic wait_cs(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (cycle_start) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no cycle_start within 100 clks", name);
    end
  endtask

  task automatic expect_per(input string name, input int len, input logic [7:0][7:0] hi);
    per_t e;
    e.name   = name;
    e.len    = len;
    e.hi     = hi;
    e.t_push = $time;
    per_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && per_q.size() > 0; i++) @(negedge clk);
    if (per_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d period windows never observed", name, per_q.size());
      per_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0][7:0] h;
    bit any_cs;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;

    #23;
    check("reset pwm_out", 64'(pwm_out), 64'h0);
    check("reset cycle_start", 64'(cycle_start), 64'h0);
    check("reset rd_data", 64'(bus.rd_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst period", 4'd8, 16'h0);
    rd("rst ctrl", 4'd11, 16'h0);

    // Basic duty: 3 of 10
    wr(4'd8, 16'd9);
    wr(4'd9, 16'd0);
    wr(4'd0, 16'd3);
    wr(4'd10, 16'd1);
    wr(4'd11, 16'd1);
    rd("rd period", 4'd8, 16'd9);
    rd("rd duty0", 4'd0, 16'd3);
    rd("rd en", 4'd10, 16'd1);
    rd("rd ctrl", 4'd11, 16'd1);
    wr(4'd13, 16'hBEEF);
    rd("rd unmapped 13", 4'd13, 16'h0);
    rd("rd unmapped 15", 4'd15, 16'h0);
    wait_cs("basic settle");
    h = '0; h[0] = 8'd3;
    expect_per("basic a", 10, h);
    expect_per("basic b", 10, h);
    drain("basic");

    // Boundary duties, then inverted
    wr(4'd0, 16'd0);
    wr(4'd1, 16'd10);
    wr(4'd10, 16'd3);
    wait_cs("boundary settle 1");
    wait_cs("boundary settle 2");
    h = '0; h[1] = 8'd10;
    expect_per("boundary", 10, h);
    drain("boundary");
    wr(4'd11, 16'd3);
    wait_cs("invert settle 1");
    wait_cs("invert settle 2");
    h = {8{8'd10}}; h[1] = 8'd0;
    expect_per("invert", 10, h);
    drain("invert");

    // Double buffering: mid-period write, then write coincident with the wrap
    wr(4'd11, 16'd1);
    wr(4'd10, 16'd1);
    wr(4'd0, 16'd5);
    wait_cs("dbuf settle 1");
    wait_cs("dbuf settle 2");
    wait_cs("dbuf start");
    h = '0; h[0] = 8'd5;
    expect_per("dbuf current", 10, h);
    h[0] = 8'd2;
    expect_per("dbuf next", 10, h);
    repeat (3) @(posedge clk);
    wr(4'd0, 16'd2);
    drain("dbuf");
    wait_cs("coinc start");
    h = '0; h[0] = 8'd2;
    expect_per("coinc current", 10, h);
    expect_per("coinc after wrap", 10, h);
    h[0] = 8'd7;
    expect_per("coinc next", 10, h);
    repeat (9) @(posedge clk);
    #1;
    bus.wr_en   = 1'b1;
    bus.addr    = 4'd0;
    bus.wr_data = 16'd7;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
    drain("coinc");

    // Prescaler: (3+1)*(4+1) = 20 clks per period, duty 2 -> 8 high
    wr(4'd9, 16'hAB03);
    wr(4'd8, 16'd4);
    wr(4'd0, 16'd2);
    rd("rd presc truncated", 4'd9, 16'd3);
    wait_cs("presc settle 1");
    wait_cs("presc settle 2");
    h = '0; h[0] = 8'd8;
    expect_per("presc a", 20, h);
    expect_per("presc b", 20, h);
    drain("presc");

    // Enable mask 0x0A: only channels 1 and 3
    wr(4'd9, 16'd0);
    wr(4'd8, 16'd9);
    wr(4'd0, 16'd3);
    wr(4'd1, 16'd4);
    wr(4'd2, 16'd5);
    wr(4'd3, 16'd6);
    wr(4'd10, 16'hFF0A);
    rd("rd en truncated", 4'd10, 16'h000A);
    wait_cs("en settle 1");
    wait_cs("en settle 2");
    h = '0; h[1] = 8'd4; h[3] = 8'd6;
    expect_per("enable", 10, h);
    drain("enable");

    // Stop with invert: outputs go to invert level, no cycle_start
    wr(4'd11, 16'd2);
    @(posedge clk); #1;
    check("stop pwm invert level", 64'(pwm_out), 64'hFF);
    any_cs = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (cycle_start) any_cs = 1'b1;
    end
    check("stop no cycle_start", 64'(any_cs), 64'h0);
    check("stop pwm held", 64'(pwm_out), 64'hFF);

    // Asynchronous reset mid-period
    wr(4'd11, 16'd1);
    wait_cs("reset run");
    repeat (3) @(negedge clk);
    check("pre-reset pwm", 64'(pwm_out), 64'h0A);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset pwm", 64'(pwm_out), 64'h0);
    check("async reset cycle_start", 64'(cycle_start), 64'h0);
    check("async reset rd_data", 64'(bus.rd_data), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd("post duty0", 4'd0, 16'h0);
    rd("post duty3", 4'd3, 16'h0);
    rd("post period", 4'd8, 16'h0);
    rd("post presc", 4'd9, 16'h0);
    rd("post en", 4'd10, 16'h0);
    rd("post ctrl", 4'd11, 16'h0);
    @(negedge clk);
    check("post reset pwm", 64'(pwm_out), 64'h0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
